// File: rtl/ahb3lite_pkg.sv
// rtl/ahb3lite_pkg.sv - shared AHB3-Lite / APB4 constants and helper functions
package ahb3lite_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam int PPROT_PRIVILEGED  = 0;
  localparam int PPROT_NONSECURE   = 1;
  localparam int PPROT_INSTRUCTION = 2;

  function automatic logic is_active_trans(input logic [1:0] htrans);
    return (htrans == HTRANS_NONSEQ) || (htrans == HTRANS_SEQ);
  endfunction

  function automatic logic hsize_legal(input logic [2:0] hsize, input logic [2:0] max_hsize);
    return hsize <= max_hsize;
  endfunction

  // Strobe for up to a 64-bit bus; callers keep the low HDATA_SIZE/8 bits.
  function automatic logic [7:0] gen_pstrb(input logic [2:0] hsize, input logic [2:0] haddr_lsbs);
    logic [3:0]  nbytes;
    logic [2:0]  offset;
    logic [15:0] mask;
    nbytes = 4'd1 << hsize[1:0];
    mask   = (16'd1 << nbytes) - 16'd1;
    offset = haddr_lsbs & ~3'(nbytes - 4'd1);
    return 8'(mask << offset);
  endfunction

endpackage

// File: rtl/ahb3lite_apb4_bridge.sv
// rtl/ahb3lite_apb4_bridge.sv - AHB3-Lite slave to APB4 master bridge, one APB transfer per AHB beat
module ahb3lite_apb4_bridge
  import ahb3lite_pkg::*;
#(
  parameter int HADDR_SIZE = 32,
  parameter int HDATA_SIZE = 32,
  parameter int PADDR_SIZE = 16
) (
  input  logic                    HRESETn,
  input  logic                    HCLK,
  input  logic                    HSEL,
  input  logic [HADDR_SIZE-1:0]   HADDR,
  input  logic [HDATA_SIZE-1:0]   HWDATA,
  output logic [HDATA_SIZE-1:0]   HRDATA,
  input  logic                    HWRITE,
  input  logic [2:0]              HSIZE,
  input  logic [2:0]              HBURST,
  input  logic [3:0]              HPROT,
  input  logic [1:0]              HTRANS,
  input  logic                    HMASTLOCK,
  input  logic                    HREADY,
  output logic                    HREADYOUT,
  output logic                    HRESP,
  output logic                    PSEL,
  output logic                    PENABLE,
  output logic [2:0]              PPROT,
  output logic                    PWRITE,
  output logic [HDATA_SIZE/8-1:0] PSTRB,
  output logic [PADDR_SIZE-1:0]   PADDR,
  output logic [HDATA_SIZE-1:0]   PWDATA,
  input  logic [HDATA_SIZE-1:0]   PRDATA,
  input  logic                    PREADY,
  input  logic                    PSLVERR
);

  localparam int         STRB_W    = HDATA_SIZE / 8;
  localparam int         BYTES_LOG = $clog2(STRB_W);
  localparam logic [2:0] MAX_HSIZE = 3'(BYTES_LOG);
  localparam logic [2:0] LSB_MASK  = 3'((1 << BYTES_LOG) - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_ACCESS,
    ST_ERR1,
    ST_ERR2
  } state_e;

  state_e                  state_q, state_d;
  logic [PADDR_SIZE-1:0]   paddr_q;
  logic                    pwrite_q;
  logic [STRB_W-1:0]       pstrb_q, pstrb_d;
  logic [2:0]              pprot_q, pprot_d;
  logic [HDATA_SIZE-1:0]   hrdata_q;
  logic                    hreadyout_q, hresp_q;
  logic                    accept;
  logic [7:0]              strb_full;
  logic                    unused_inputs;

  assign accept    = (state_q == ST_IDLE) & HSEL & HREADY & is_active_trans(HTRANS);
  assign strb_full = gen_pstrb(HSIZE, HADDR[2:0] & LSB_MASK);
  assign pstrb_d   = HWRITE ? strb_full[STRB_W-1:0] : '0;

  always_comb begin
    pprot_d                    = '0;
    pprot_d[PPROT_PRIVILEGED]  = HPROT[1];
    pprot_d[PPROT_NONSECURE]   = 1'b1;
    pprot_d[PPROT_INSTRUCTION] = ~HPROT[0];
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:   if (accept) state_d = hsize_legal(HSIZE, MAX_HSIZE) ? ST_SETUP : ST_ERR1;
      ST_SETUP:  state_d = ST_ACCESS;
      ST_ACCESS: if (PREADY) state_d = PSLVERR ? ST_ERR1 : ST_IDLE;
      ST_ERR1:   state_d = ST_ERR2;
      ST_ERR2:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    PSEL    = 1'b0;
    PENABLE = 1'b0;
    unique case (state_q)
      ST_SETUP:  PSEL = 1'b1;
      ST_ACCESS: begin
        PSEL    = 1'b1;
        PENABLE = 1'b1;
      end
      default: ;
    endcase
  end

  // AHB response flags are registered from the next state so they line up with it.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      hreadyout_q <= 1'b1;
      hresp_q     <= 1'b0;
    end else begin
      hreadyout_q <= (state_d == ST_IDLE) || (state_d == ST_ERR2);
      hresp_q     <= (state_d == ST_ERR1) || (state_d == ST_ERR2);
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      paddr_q  <= '0;
      pwrite_q <= 1'b0;
      pstrb_q  <= '0;
      pprot_q  <= '0;
    end else if (accept) begin
      paddr_q  <= HADDR[PADDR_SIZE-1:0];
      pwrite_q <= HWRITE;
      pstrb_q  <= pstrb_d;
      pprot_q  <= pprot_d;
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      hrdata_q <= '0;
    end else if ((state_q == ST_ACCESS) && PREADY && !PSLVERR && !pwrite_q) begin
      hrdata_q <= PRDATA;
    end
  end

  assign HREADYOUT = hreadyout_q;
  assign HRESP     = hresp_q;
  assign HRDATA    = hrdata_q;
  assign PADDR     = paddr_q;
  assign PWRITE    = pwrite_q;
  assign PSTRB     = pstrb_q;
  assign PPROT     = pprot_q;
  // The master holds HWDATA stable while HREADYOUT is low, so it can pass straight through.
  assign PWDATA    = PSEL ? HWDATA : '0;

  assign unused_inputs = ^{HBURST, HMASTLOCK, HADDR, HPROT[3:2], strb_full};

endmodule

// File: tb/tb_ahb3lite_apb4_bridge.sv
// tb/tb_ahb3lite_apb4_bridge.sv - randomized self-checking bench for ahb3lite_apb4_bridge
module tb_ahb3lite_apb4_bridge;

  logic        HRESETn, HCLK;
  logic        HSEL, HWRITE, HMASTLOCK, HREADY;
  logic [31:0] HADDR, HWDATA, HRDATA;
  logic [2:0]  HSIZE, HBURST;
  logic [3:0]  HPROT;
  logic [1:0]  HTRANS;
  logic        HREADYOUT, HRESP;
  logic        PSEL, PENABLE, PWRITE, PREADY, PSLVERR;
  logic [2:0]  PPROT;
  logic [3:0]  PSTRB;
  logic [15:0] PADDR;
  logic [31:0] PWDATA, PRDATA;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] model_hrdata = '0;

  ahb3lite_apb4_bridge #(.HADDR_SIZE(32), .HDATA_SIZE(32), .PADDR_SIZE(16)) dut (
    .HRESETn(HRESETn), .HCLK(HCLK), .HSEL(HSEL), .HADDR(HADDR), .HWDATA(HWDATA),
    .HRDATA(HRDATA), .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST), .HPROT(HPROT),
    .HTRANS(HTRANS), .HMASTLOCK(HMASTLOCK), .HREADY(HREADY), .HREADYOUT(HREADYOUT),
    .HRESP(HRESP), .PSEL(PSEL), .PENABLE(PENABLE), .PPROT(PPROT), .PWRITE(PWRITE),
    .PSTRB(PSTRB), .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY),
    .PSLVERR(PSLVERR)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", tag, got, exp);
    end
  endtask

  // Bus status vector: {PSEL, PENABLE, HREADYOUT, HRESP}
  task automatic idle_gap(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge HCLK);
      HSEL   = 1'($urandom);
      HTRANS = 2'($urandom_range(0, 1));
      HREADY = 1'b1;
      HADDR  = $urandom;
      HWRITE = 1'($urandom);
      PREADY = 1'($urandom);
      #1;
      check("idle_bus", 64'({PSEL, PENABLE, HREADYOUT, HRESP}), 64'(4'b0010));
      check("idle_hrdata", 64'(HRDATA), 64'(model_hrdata));
    end
  endtask

  // Entered with the DUT idle, just after a falling edge; presents one address phase
  // and follows the transfer to its final zero-wait OKAY cycle.
  task automatic do_xfer(input logic [31:0] addr, input logic wr, input logic [2:0] size,
                         input logic [3:0] prot, input logic [31:0] wdata,
                         input logic [31:0] rdata, input int waits, input logic slverr);
    bit         legal, err;
    int         nb, off, e0, last;
    logic [3:0] exp_strb, exp_bus;
    logic [2:0] exp_prot;
    legal    = (size <= 3'd2);
    err      = !legal || slverr;
    nb       = legal ? (1 << size) : 1;
    off      = (int'(addr[1:0]) / nb) * nb;
    exp_strb = wr ? 4'(((1 << nb) - 1) << off) : 4'b0000;
    exp_prot = {~prot[0], 1'b1, prot[1]};
    e0       = legal ? 2 + waits : 0;
    last     = err ? e0 + 2 : e0;

    HSEL = 1'b1; HTRANS = 2'b10; HADDR = addr; HWRITE = wr; HSIZE = size; HPROT = prot;
    HREADY = 1'b1; HBURST = 3'($urandom); HMASTLOCK = 1'($urandom);
    for (int c = 0; c <= last; c++) begin
      @(negedge HCLK);
      HTRANS  = 2'($urandom_range(0, 1));
      HSEL    = 1'($urandom);
      HREADY  = (c == last);
      HADDR   = $urandom;
      if (c == 0) HWDATA = wdata;
      PREADY  = legal && (c == 1 + waits);
      PSLVERR = PREADY ? slverr : 1'($urandom);
      PRDATA  = PREADY ? rdata : $urandom;
      #1;
      if (legal && c == 0)                exp_bus = 4'b1000;
      else if (legal && c <= 1 + waits)   exp_bus = 4'b1100;
      else if (err && c == e0)            exp_bus = 4'b0001;
      else if (err && c == e0 + 1)        exp_bus = 4'b0011;
      else                                exp_bus = 4'b0010;
      check("bus", 64'({PSEL, PENABLE, HREADYOUT, HRESP}), 64'(exp_bus));
      if (exp_bus[3]) begin
        check("paddr",  64'(PADDR),  64'(addr[15:0]));
        check("pwrite", 64'(PWRITE), 64'(wr));
        check("pstrb",  64'(PSTRB),  64'(exp_strb));
        check("pprot",  64'(PPROT),  64'(exp_prot));
        check("pwdata", 64'(PWDATA), 64'(wdata));
      end else begin
        check("pwdata_off", 64'(PWDATA), 64'(0));
      end
    end
    if (legal && !slverr && !wr) model_hrdata = rdata;
    check("hrdata", 64'(HRDATA), 64'(model_hrdata));
  endtask

  initial begin
    logic [2:0] sz;
    HRESETn = 1'b0; HSEL = 0; HADDR = '0; HWDATA = '0; HWRITE = 0; HSIZE = '0; HBURST = '0;
    HPROT = '0; HTRANS = '0; HMASTLOCK = 0; HREADY = 1; PRDATA = '0; PREADY = 0; PSLVERR = 0;
    repeat (2) @(negedge HCLK);
    #1;
    check("rst_bus",    64'({PSEL, PENABLE, HREADYOUT, HRESP}), 64'(4'b0010));
    check("rst_pwrite", 64'(PWRITE), 64'(0));
    check("rst_paddr",  64'(PADDR),  64'(0));
    check("rst_pstrb",  64'(PSTRB),  64'(0));
    check("rst_pprot",  64'(PPROT),  64'(0));
    check("rst_hrdata", 64'(HRDATA), 64'(0));
    @(negedge HCLK);
    HRESETn = 1'b1;
    idle_gap(2);

    HSEL = 1; HTRANS = 2'b10; HADDR = 32'h40; HWRITE = 1; HSIZE = 3'd2; HPROT = 4'h2; HREADY = 1;
    @(negedge HCLK);
    HTRANS = 2'b00; HWDATA = 32'hA5A5_0001; PREADY = 0;
    #1;
    check("mid_setup", 64'({PSEL, PENABLE, HREADYOUT, HRESP}), 64'(4'b1000));
    @(negedge HCLK);
    #1;
    check("mid_access", 64'({PSEL, PENABLE, HREADYOUT, HRESP}), 64'(4'b1100));
    HRESETn = 1'b0;
    #1;
    check("mid_rst_bus",   64'({PSEL, PENABLE, HREADYOUT, HRESP}), 64'(4'b0010));
    check("mid_rst_paddr", 64'(PADDR), 64'(0));
    check("mid_rst_pstrb", 64'(PSTRB), 64'(0));
    @(negedge HCLK);
    HRESETn = 1'b1;
    model_hrdata = '0;
    idle_gap(2);

    do_xfer(32'h0000_1234, 1'b1, 3'd2, 4'h3, 32'hDEAD_BEEF, 32'h0, 0, 1'b0);
    do_xfer(32'h0000_0003, 1'b0, 3'd0, 4'h1, 32'h0, 32'h1122_3344, 4, 1'b0);
    do_xfer(32'h0000_0100, 1'b1, 3'd2, 4'h0, 32'h0BAD_F00D, 32'h0, 1, 1'b1);
    do_xfer(32'h0000_0008, 1'b1, 3'd3, 4'h2, 32'h1357_9BDF, 32'h0, 0, 1'b0);
    idle_gap(1);
    do_xfer(32'h0000_0002, 1'b1, 3'd1, 4'h3, 32'hCAFE_0000, 32'h0, 0, 1'b0);
    do_xfer(32'h0000_0004, 1'b0, 3'd2, 4'h0, 32'h0, 32'h55AA_C33C, 0, 1'b0);
    idle_gap(4);

    for (int i = 0; i < 80; i++) begin
      if ($urandom_range(0, 5) == 0) sz = 3'($urandom_range(3, 7));
      else                           sz = 3'($urandom_range(0, 2));
      do_xfer($urandom, 1'($urandom), sz, 4'($urandom), $urandom, $urandom,
              ($urandom_range(0, 3) == 0) ? $urandom_range(2, 6) : $urandom_range(0, 1),
              ($urandom_range(0, 4) == 0));
      if ($urandom_range(0, 2) == 0) idle_gap($urandom_range(1, 3));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ahb3lite_apb4_bridge.md
Name: ahb3lite_apb4_bridge

Overview:
- Converts one AHB3-Lite slave port into a single APB4 master interface. HCLK and PCLK are the same clock.
- Sits directly downstream of one master port (slv_*) of the multi-layer switch. Connects to the HSEL/HADDR/HTRANS/HREADY/HREADYOUT/HRESP set that the switch drives.
- Lets low-bandwidth peripherals share one switch port. Each AHB transfer becomes exactly one APB SETUP+ACCESS transfer.

Parameters:
- HADDR_SIZE, 32, AHB address width.
- HDATA_SIZE, 32, AHB data width. It is also the APB data width; only 8/16/32/64 are legal.
- PADDR_SIZE, 16, APB address width. It must be ≤ HADDR_SIZE. PADDR = HADDR[PADDR_SIZE-1:0].

Ports:
- HRESETn  in  1  asynchronous active-low reset
- HCLK  in  1  clock; the APB side runs on it too
- HSEL  in  1  port select from the switch
- HADDR  in  HADDR_SIZE  address
- HWDATA  in  HDATA_SIZE  write data (data phase)
- HRDATA  out  HDATA_SIZE  read data, registered
- HWRITE  in  1  write = 1
- HSIZE  in  3  transfer size
- HBURST  in  3  ignored; every beat is handled independently
- HPROT  in  4  protection
- HTRANS  in  2  IDLE/BUSY/NONSEQ/SEQ
- HMASTLOCK  in  1  ignored
- HREADY  in  1  bus ready, sampled with the address phase
- HREADYOUT  out  1  bridge ready, registered
- HRESP  out  1  1 = ERROR, registered
- PSEL  out  1  APB select
- PENABLE  out  1  APB enable
- PPROT  out  3  APB protection
- PWRITE  out  1  APB direction
- PSTRB  out  HDATA_SIZE/8  APB write strobes
- PADDR  out  PADDR_SIZE  APB address
- PWDATA  out  HDATA_SIZE  APB write data
- PRDATA  in  HDATA_SIZE  APB read data
- PREADY  in  1  APB ready
- PSLVERR  in  1  APB error

Behaviour:
- Reset (async assert, sync release):
  - State = IDLE.
  - PSEL = PENABLE = PWRITE = 0. PADDR, PSTRB, PPROT and HRDATA all 0.
  - HREADYOUT = 1, HRESP = 0.
- Transfer accept: the address phase is sampled when HSEL & HREADY & (HTRANS == NONSEQ or SEQ), in IDLE.
  - HADDR, HWRITE, HSIZE and HPROT are registered.
  - Illegal size: if HSIZE > log2(HDATA_SIZE/8), go to ERR1. No APB access is made.
- IDLE or BUSY transfers, and HSEL = 0: zero-wait OKAY. The state does not change.
- States:
  - IDLE: HREADYOUT = 1. On accept → SETUP (or ERR1 for an illegal size).
  - SETUP: PSEL = 1, PENABLE = 0, HREADYOUT = 0. Always → ACCESS after one cycle.
  - ACCESS: PSEL = 1, PENABLE = 1, HREADYOUT = 0.
    - PREADY = 0: stay; wait states are unlimited.
    - PREADY & ~PSLVERR → IDLE. That edge registers HRDATA ← PRDATA (reads only) and sets HREADYOUT = 1, HRESP = 0.
    - PREADY & PSLVERR → ERR1.
  - ERR1: HREADYOUT = 0, HRESP = 1, PSEL = 0 → ERR2.
  - ERR2: HREADYOUT = 1, HRESP = 1 → IDLE. This is the AHB two-cycle error response. A new transfer is not accepted in ERR2; the master cancels it per the AHB protocol.
- A new address phase presented in the cycle where HREADYOUT = 1 (IDLE) is accepted.
  - Minimum back-to-back period is 3 cycles per transfer: SETUP, ACCESS, complete.
- PWDATA = HWDATA, combinational. It is valid because the AHB master holds HWDATA stable while HREADYOUT = 0. PWDATA is 0 when PSEL = 0.
- PSTRB:
  - Reads: all zeros.
  - Writes: (2^(2^HSIZE) − 1) shifted left by HADDR[log2(HDATA_SIZE/8)-1:0], aligned down to the HSIZE boundary.
  - Example (HDATA_SIZE = 32): halfword at offset 2 → 4'b1100.
- PPROT:
  - [0] = HPROT[1] (privileged).
  - [1] = 1 (non-secure).
  - [2] = ~HPROT[0] (instruction).
- PADDR, PWRITE, PSTRB and PPROT stay stable from SETUP until the ACCESS exit.
- HRDATA holds its last value except on a read completion.

Decomposition:
- Add to ahb3lite_pkg:
  - an HTRANS/HSIZE localparam check function;
  - APB4 PPROT bit-position constants;
  - the strobe-generation function gen_pstrb(hsize, haddr_lsbs).
- The state enum (IDLE, SETUP, ACCESS, ERR1, ERR2) is local to the module.
- There is no sub-module; the block is a single FSM plus registers.

Test Plan:
- Reset mid-ACCESS (PREADY held 0) → PSEL = PENABLE = 0 and HREADYOUT = 1 immediately on HRESETn = 0; state IDLE after release.
- Word write 0xDEADBEEF to 0x0000_1234, PREADY = 1 → PSEL at T+1, PENABLE at T+2. PADDR = 0x1234, PSTRB = 4'b1111, PWDATA = 0xDEADBEEF. HREADYOUT = 1 at T+3.
- Byte read at 0x0000_0003, PREADY low 4 cycles, PRDATA = 0x1122_3344 → PSTRB = 0, ACCESS lasts 5 cycles, HRDATA = 0x1122_3344 with HREADYOUT = 1, HRESP = 0.
- Write with PSLVERR = 1 at PREADY → two cycles of HRESP = 1, with HREADYOUT 0 then 1, then back to IDLE.
- HSIZE = 3'b011 on the 32-bit bus → ERR1/ERR2 response; PSEL never asserted.
- Back-to-back NONSEQ pair (halfword write at 0x2, then read at 0x4) → second SETUP directly after the first completion cycle; PSTRB 4'b1100, then 0000. HTRANS = IDLE/BUSY cycles give zero-wait OKAY with PSEL = 0.
